// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op-class helper for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC1,
    S_BUSY,
    S_DONE
  } alu_state_t;

  // True for the four codes served by the iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (radix-2 shift-add) and restoring divide.
// hi/lo form a 2*WIDTH accumulator: product high/low for multiply,
// remainder/quotient for divide. done flags the cycle whose edge completes
// the final iteration; hi_next/lo_next carry that final value.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] operand;
  logic             div_mode;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;

  assign done = busy && (count == CNT_W'(WIDTH - 1));

  // One iteration step: conditional add + right shift, or trial subtract + left shift.
  always_comb begin
    add_sum   = {1'b0, hi} + {1'b0, operand};
    rem_shift = {hi, lo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, operand};
    hi_next   = hi;
    lo_next   = lo;
    if (div_mode) begin
      if (rem_shift >= {1'b0, operand}) begin
        hi_next = rem_diff[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_shift[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_next = add_sum[WIDTH:1];
      lo_next = {add_sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_next = {1'b0, hi[WIDTH-1:1]};
      lo_next = {hi[0], lo[WIDTH-1:1]};
    end
  end

  // Load operands on start, then step once per cycle for WIDTH cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi       <= '0;
      lo       <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
      busy     <= 1'b0;
      count    <= '0;
    end else if (start) begin
      hi       <= '0;
      lo       <= is_div ? a : b;
      operand  <= is_div ? b : a;
      div_mode <= is_div;
      busy     <= 1'b1;
      count    <= '0;
    end else if (busy) begin
      hi    <= hi_next;
      lo    <= lo_next;
      count <= count + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake. Single-cycle ops finish one
// edge after accept; MUL/MULHU/DIVU/REMU run WIDTH iterations in the
// optional iterative unit. At most one op is in flight.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_t         state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         op_q;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               accept;
  logic               md_op;
  logic               md_start;
  logic               md_done;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   md_lo;
  logic [WIDTH-1:0]   md_res;

  assign accept   = in_valid && in_ready;
  assign md_op    = (ENABLE_MULDIV != 0) && is_muldiv(ALUControl);
  assign md_start = accept && md_op;
  assign shamt    = b_q[SHAMT_W-1:0];
  assign md_res   = op_q[0] ? md_hi : md_lo;

  generate
    if (ENABLE_MULDIV != 0) begin : g_muldiv
      alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start   (md_start),
        .is_div  (ALUControl[2]),
        .a       (A),
        .b       (B),
        .done    (md_done),
        .hi_next (md_hi),
        .lo_next (md_lo)
      );
    end else begin : g_no_muldiv
      assign md_done = 1'b0;
      assign md_hi   = '0;
      assign md_lo   = '0;
    end
  endgenerate

  // Single-cycle datapath and carry/overflow on the latched operands.
  always_comb begin
    sum_add = {1'b0, a_q} + {1'b0, b_q};
    sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH + 1)'(1);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      ALU_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_add[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum_sub[WIDTH-1] != a_q[WIDTH-1]);
      end
      ALU_AND:  alu_res = a_q & b_q;
      ALU_OR:   alu_res = a_q | b_q;
      ALU_XOR:  alu_res = a_q ^ b_q;
      ALU_SLT:  alu_res = WIDTH'($signed(a_q) < $signed(b_q));
      ALU_SLTU: alu_res = WIDTH'(a_q < b_q);
      ALU_SLL:  alu_res = a_q << shamt;
      ALU_SRL:  alu_res = a_q >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      Result    <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= ALUControl;
            in_ready <= 1'b0;
            state    <= md_op ? S_BUSY : S_EXEC1;
          end
        end
        S_EXEC1: begin
          Result    <= alu_res;
          N         <= alu_res[WIDTH-1];
          Z         <= (alu_res == '0);
          C         <= alu_c;
          V         <= alu_v;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_BUSY: begin
          if (md_done) begin
            Result    <= md_res;
            N         <= md_res[WIDTH-1];
            Z         <= (md_res == '0);
            C         <= 1'b0;
            V         <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized
// ops compared against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALUControl = '0;
  logic        in_ready, out_valid, N, Z, C, V;
  logic [31:0] Result;

  int checks = 0;
  int passes = 0;

  alu_seq #(.WIDTH(32), .ENABLE_MULDIV(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .N          (N),
    .Z          (Z),
    .C          (C),
    .V          (V)
  );

  always #5 clk = ~clk;

  // Reference model: plain wide arithmetic from the op definitions.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] f);
    logic [63:0] prod;
    logic [32:0] wide;
    longint      s;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        c = wide[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: r = $unsigned($signed(a) >>> b[4:0]);
      4'd10: r = prod[31:0];
      4'd11: r = prod[63:32];
      4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endtask

  // Issue one op, wait (bounded) for the result, then complete the handshake.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] f, output int lat,
                        output bit ready_leak);
    int w;
    ready_leak = 0;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    A = a;
    B = b;
    ALUControl = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUControl = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_leak = 1;
      A = $urandom;
      B = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = Result;
    f = {N, Z, C, V};
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, Result, N, Z, C, V} !== {1'b0, 1'b1, 32'd0, 4'b0000})
      $display("[TB] FAIL reset_state: got valid=%b ready=%b res=%h flags=%b, expected 0 1 0 0000",
               out_valid, in_ready, Result, {N, Z, C, V});
    else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_sub();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    bit          leak;
    run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, r, f, lat, leak);
    checks++;
    if ({r, f} !== {32'h8000_0000, 4'b1001})
      $display("[TB] FAIL add_overflow: got %h/%b expected 80000000/1001", r, f);
    else passes++;
    checks++;
    if (lat !== 1) $display("[TB] FAIL add_latency: got %0d expected 1", lat);
    else passes++;
    run_op(4'd1, 32'd5, 32'd5, r, f, lat, leak);
    checks++;
    if ({r, f} !== {32'h0, 4'b0110})
      $display("[TB] FAIL sub_zero: got %h/%b expected 00000000/0110", r, f);
    else passes++;
    run_op(4'd1, 32'd0, 32'd1, r, f, lat, leak);
    checks++;
    if ({r, f} !== {32'hFFFF_FFFF, 4'b1000})
      $display("[TB] FAIL sub_borrow: got %h/%b expected ffffffff/1000", r, f);
    else passes++;
  endtask

  task automatic test_muldiv();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    bit          leak;
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat, leak);
    checks++;
    if (r !== 32'h1) $display("[TB] FAIL mul_low: got %h expected 00000001", r);
    else passes++;
    checks++;
    if (lat !== 32 || leak) $display("[TB] FAIL mul_latency: got %0d leak=%0d expected 32 leak=0", lat, leak);
    else passes++;
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, f, lat, leak);
    checks++;
    if (r !== 32'hFFFF_FFFE) $display("[TB] FAIL mulhu: got %h expected fffffffe", r);
    else passes++;
    checks++;
    if (lat !== 32 || leak) $display("[TB] FAIL mulhu_latency: got %0d leak=%0d expected 32 leak=0", lat, leak);
    else passes++;
    run_op(4'd12, 32'd7, 32'd0, r, f, lat, leak);
    checks++;
    if (r !== 32'hFFFF_FFFF || lat !== 32)
      $display("[TB] FAIL divu_by_zero: got %h lat %0d expected ffffffff lat 32", r, lat);
    else passes++;
    run_op(4'd13, 32'd7, 32'd0, r, f, lat, leak);
    checks++;
    if (r !== 32'd7) $display("[TB] FAIL remu_by_zero: got %h expected 00000007", r);
    else passes++;
    run_op(4'd12, 32'd100, 32'd7, r, f, lat, leak);
    checks++;
    if (r !== 32'd14) $display("[TB] FAIL divu: got %0d expected 14", r);
    else passes++;
    run_op(4'd13, 32'd100, 32'd7, r, f, lat, leak);
    checks++;
    if (r !== 32'd2) $display("[TB] FAIL remu: got %0d expected 2", r);
    else passes++;
  endtask

  task automatic test_shift_compare();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    bit          leak;
    run_op(4'd9, 32'h8000_0000, 32'h0000_0024, r, f, lat, leak);
    checks++;
    if (r !== 32'hF800_0000) $display("[TB] FAIL sra: got %h expected f8000000", r);
    else passes++;
    run_op(4'd5, 32'h8000_0000, 32'd1, r, f, lat, leak);
    checks++;
    if (r !== 32'd1) $display("[TB] FAIL slt: got %h expected 00000001", r);
    else passes++;
    run_op(4'd6, 32'h8000_0000, 32'd1, r, f, lat, leak);
    checks++;
    if (r !== 32'd0) $display("[TB] FAIL sltu: got %h expected 00000000", r);
    else passes++;
  endtask

  task automatic test_hold();
    int w;
    @(negedge clk);
    A = 32'h1234_0000;
    B = 32'h0000_5678;
    ALUControl = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      A = $urandom;
      B = $urandom;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, Result} !== {1'b1, 1'b0, 32'h1234_5678})
        $display("[TB] FAIL hold_done: got valid=%b ready=%b res=%h expected 1 0 12345678",
                 out_valid, in_ready, Result);
      else passes++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("[TB] FAIL after_handshake: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    bit          leak;
    @(negedge clk);
    A = 32'hDEAD_BEEF;
    B = 32'h0000_1003;
    ALUControl = 4'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, Result, N, Z, C, V} !== {1'b0, 1'b1, 32'd0, 4'b0000})
      $display("[TB] FAIL reset_mid_busy: got valid=%b ready=%b res=%h flags=%b expected 0 1 0 0000",
               out_valid, in_ready, Result, {N, Z, C, V});
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    run_op(4'd0, 32'd3, 32'd4, r, f, lat, leak);
    checks++;
    if ({r, f, lat} !== {32'd7, 4'b0000, 32'd1})
      $display("[TB] FAIL add_after_reset: got %h/%b lat %0d expected 00000007/0000 lat 1", r, f, lat);
    else passes++;
  endtask

  task automatic test_random();
    logic [31:0] r, er, a, b;
    logic [3:0]  f, ef, op;
    int          lat, elat;
    bit          leak;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ref_model(op, a, b, er, ef);
      elat = (op >= 4'd10 && op <= 4'd13) ? 32 : 1;
      run_op(op, a, b, r, f, lat, leak);
      checks++;
      if ({r, f} !== {er, ef})
        $display("[TB] FAIL random_op%0d op=%0d a=%h b=%h: got %h/%b expected %h/%b",
                 i, op, a, b, r, f, er, ef);
      else passes++;
      checks++;
      if (lat !== elat || leak)
        $display("[TB] FAIL random_latency%0d op=%0d: got %0d leak=%0d expected %0d leak=0",
                 i, op, lat, leak, elat);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_muldiv();
    test_shift_compare();
    test_hold();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
